// File: rtl/dm_arbiter_pkg.sv
// Shared encodings and lane helpers for the data-memory arbiter: byte enables,
// store lane replication, load extraction and alignment checks.
package dm_arbiter_pkg;

  localparam logic [1:0]  SIZE_BYTE    = 2'b00;
  localparam logic [1:0]  SIZE_HALF    = 2'b01;
  localparam logic [1:0]  SIZE_WORD    = 2'b10;
  localparam logic [31:0] DM_LIMIT_DEF = 32'h0000_3000;

  function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SIZE_BYTE: be = 4'b0001 << off;
      SIZE_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      default:   be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] wr_rep(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] lanes;
    case (size)
      SIZE_BYTE: lanes = {4{wdata[7:0]}};
      SIZE_HALF: lanes = {2{wdata[15:0]}};
      default:   lanes = wdata;
    endcase
    return lanes;
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] size,
                                           input logic [1:0] off, input logic sext);
    logic [31:0] lane;
    logic [31:0] res;
    lane = word >> {off, 3'b000};
    case (size)
      SIZE_BYTE: res = {{24{sext & lane[7]}}, lane[7:0]};
      SIZE_HALF: res = off[1] ? {{16{sext & word[31]}}, word[31:16]}
                              : {{16{sext & word[15]}}, word[15:0]};
      default:   res = word;
    endcase
    return res;
  endfunction

  // Size code 11 behaves as a word access, so it shares the word alignment rule.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = off[0];
      default:   mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// Combinational lane logic: store byte enables and replication for the current
// access, and extraction of the registered load word for the return slot.
module dm_lane_unit
  import dm_arbiter_pkg::*;
(
  input  logic [1:0]  wr_size,
  input  logic [1:0]  wr_off,
  input  logic [31:0] wr_data,
  output logic [3:0]  wr_be,
  output logic [31:0] wr_lanes,
  input  logic [31:0] rd_word,
  input  logic [1:0]  rd_size,
  input  logic [1:0]  rd_off,
  input  logic        rd_sext,
  output logic [31:0] rd_ext
);

  assign wr_be    = be_gen(wr_size, wr_off);
  assign wr_lanes = wr_rep(wr_size, wr_data);
  assign rd_ext   = load_ext(rd_word, rd_size, rd_off, rd_sext);

endmodule

// File: rtl/dm_arbiter.sv
// Single-port data-memory arbiter between the CPU M-stage and a word DMA port,
// with DMA anti-starvation and one-cycle registered load return.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter logic [31:0] DM_LIMIT   = DM_LIMIT_DEF,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_sext,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [31:0] cpu_pc,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [31:0] dm_pc,
  output logic [3:0]  dm_be,
  input  logic [31:0] dm_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]  starve_q, starve_d;
  logic        cpu_rvalid_q, cpu_rvalid_d;
  logic        cpu_err_q, cpu_err_d;
  logic [31:0] cpu_word_q, cpu_word_d;
  logic [1:0]  ld_size_q, ld_size_d;
  logic [1:0]  ld_off_q, ld_off_d;
  logic        ld_sext_q, ld_sext_d;
  logic        dma_rvalid_q, dma_rvalid_d;
  logic [31:0] dma_rdata_q, dma_rdata_d;

  logic        starve_full;
  logic        cpu_mis;
  logic        cpu_oor;
  logic        dma_oor;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rext;
  logic        unused_dma_off;

  // DMA addresses are word-granular; the low bits are deliberately dropped.
  assign unused_dma_off = ^dma_addr[1:0];

  dm_lane_unit u_lane (
    .wr_size  (cpu_size),
    .wr_off   (cpu_addr[1:0]),
    .wr_data  (cpu_wdata),
    .wr_be    (lane_be),
    .wr_lanes (lane_wdata),
    .rd_word  (cpu_word_q),
    .rd_size  (ld_size_q),
    .rd_off   (ld_off_q),
    .rd_sext  (ld_sext_q),
    .rd_ext   (lane_rext)
  );

  // Grant selection, memory drive and next state of the counter/return slot.
  always_comb begin
    starve_full  = (starve_q == STARVE_LIM);
    cpu_mis      = misaligned(cpu_size, cpu_addr[1:0]);
    cpu_oor      = ({cpu_addr[31:2], 2'b00} >= DM_LIMIT);
    dma_oor      = ({dma_addr[31:2], 2'b00} >= DM_LIMIT);
    dma_gnt      = !reset && dma_req && (starve_full || !cpu_req);
    cpu_gnt      = !reset && cpu_req && !dma_gnt;
    dm_we        = 1'b0;
    dm_be        = 4'b0000;
    dm_addr      = 32'h0000_0000;
    dm_wdata     = 32'h0000_0000;
    dm_pc        = 32'h0000_0000;
    if (cpu_gnt) begin
      dm_addr  = cpu_addr;
      dm_wdata = lane_wdata;
      dm_pc    = cpu_pc;
      dm_be    = cpu_mis ? 4'b0000 : lane_be;
      dm_we    = cpu_we && !cpu_mis && !cpu_oor;
    end else if (dma_gnt) begin
      dm_addr  = {dma_addr[31:2], 2'b00};
      dm_wdata = dma_wdata;
      dm_be    = 4'b1111;
      dm_we    = dma_we && !dma_oor;
    end else begin
      dm_we    = 1'b0;
    end

    if (reset || !dma_req || dma_gnt) begin
      starve_d = 4'd0;
    end else if (starve_q != 4'hF) begin
      starve_d = starve_q + 4'd1;
    end else begin
      starve_d = starve_q;
    end

    // Suppressed loads still return a valid zero word in the next slot.
    cpu_rvalid_d = cpu_gnt && !cpu_we;
    cpu_err_d    = cpu_gnt && cpu_mis;
    cpu_word_d   = (cpu_rvalid_d && !cpu_mis && !cpu_oor) ? dm_rdata : 32'h0000_0000;
    ld_size_d    = cpu_rvalid_d ? cpu_size : 2'b00;
    ld_off_d     = cpu_rvalid_d ? cpu_addr[1:0] : 2'b00;
    ld_sext_d    = cpu_rvalid_d && cpu_sext;
    dma_rvalid_d = dma_gnt && !dma_we;
    dma_rdata_d  = (dma_rvalid_d && !dma_oor) ? dm_rdata : 32'h0000_0000;
  end

  // Starvation counter and read-return registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q     <= 4'd0;
      cpu_rvalid_q <= 1'b0;
      cpu_err_q    <= 1'b0;
      cpu_word_q   <= 32'h0000_0000;
      ld_size_q    <= 2'b00;
      ld_off_q     <= 2'b00;
      ld_sext_q    <= 1'b0;
      dma_rvalid_q <= 1'b0;
      dma_rdata_q  <= 32'h0000_0000;
    end else begin
      starve_q     <= starve_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      cpu_err_q    <= cpu_err_d;
      cpu_word_q   <= cpu_word_d;
      ld_size_q    <= ld_size_d;
      ld_off_q     <= ld_off_d;
      ld_sext_q    <= ld_sext_d;
      dma_rvalid_q <= dma_rvalid_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_err    = cpu_err_q;
  assign cpu_rdata  = lane_rext;
  assign dma_rvalid = dma_rvalid_q;
  assign dma_rdata  = dma_rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Randomized, self-checking bench for dm_arbiter against a byte-addressed
// reference memory and the arbitration rules.
module tb_dm_arbiter;

  logic        clk, reset;
  logic        cpu_req, cpu_we, cpu_sext;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata, cpu_pc;
  logic        cpu_gnt, cpu_rvalid, cpu_err;
  logic [31:0] cpu_rdata;
  logic        dma_req, dma_we;
  logic [31:0] dma_addr, dma_wdata;
  logic        dma_gnt, dma_rvalid;
  logic [31:0] dma_rdata;
  logic        dm_we;
  logic [31:0] dm_addr, dm_wdata, dm_pc, dm_rdata;
  logic [3:0]  dm_be;

  logic [31:0] mem [0:4095];
  logic [7:0]  ref_b [0:16383];
  int errors = 0;
  int checks = 0;

  dm_arbiter #(.DM_LIMIT(32'h0000_3000), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_sext(cpu_sext),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_pc(cpu_pc),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_pc(dm_pc),
    .dm_be(dm_be), .dm_rdata(dm_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory environment: combinational read, byte-enabled write.
  assign dm_rdata = mem[dm_addr[13:2]];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
    end else if (dm_we) begin
      for (int b = 0; b < 4; b++)
        if (dm_be[b]) mem[dm_addr[13:2]][b*8 +: 8] <= dm_wdata[b*8 +: 8];
    end
  end

  function automatic int nbytes(input logic [1:0] size);
    if (size == 2'b00) return 1;
    if (size == 2'b01) return 2;
    return 4;
  endfunction

  task automatic ref_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wd);
    for (int i = 0; i < nbytes(size); i++) ref_b[(addr + i) & 16383] = wd[8*i +: 8];
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size, input logic sext);
    logic [31:0] v;
    int n;
    n = nbytes(size);
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_b[(addr + i) & 16383]) << (8*i));
    if (sext && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = 2'b00; cpu_sext = 1'b0;
    cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_pc = 32'h0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0;
  endtask

  task automatic set_cpu(input logic we, input logic [1:0] size, input logic sext,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] pc);
    cpu_req = 1'b1; cpu_we = we; cpu_size = size; cpu_sext = sext;
    cpu_addr = addr; cpu_wdata = wd; cpu_pc = pc;
  endtask

  task automatic set_dma(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    cpu_req = 1'b1; dma_req = 1'b1;
    step();
    step();
    checks++;
    if ({cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, cpu_err, dm_we, dm_be} !== 10'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 0", {cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, cpu_err, dm_we, dm_be});
    end
    checks++;
    if ({cpu_rdata, dma_rdata, dm_addr, dm_wdata, dm_pc} !== 160'b0) begin
      errors++;
      $display("FAIL reset_data: got %h required 0", {cpu_rdata, dma_rdata, dm_addr, dm_wdata, dm_pc});
    end
    reset = 1'b0;
    idle_inputs();
    step();
  endtask

  task automatic test_byte();
    logic [31:0] exp;
    set_cpu(1'b1, 2'b00, 1'b0, 32'h5, 32'h0000_00AB, 32'h0000_0100);
    #1;
    checks++;
    if ({cpu_gnt, dm_we, dm_be} !== 6'b11_0010) begin
      errors++; $display("FAIL sb_ctrl: got %b required 110010", {cpu_gnt, dm_we, dm_be});
    end
    checks++;
    if ({dm_wdata, dm_addr, dm_pc} !== {32'hABAB_ABAB, 32'h5, 32'h100}) begin
      errors++; $display("FAIL sb_data: got %h %h %h required ababab ab 5 100", dm_wdata, dm_addr, dm_pc);
    end
    ref_store(32'h5, 2'b00, 32'hAB);
    step();
    checks++;
    if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL sb_rvalid: got %b required 0", cpu_rvalid); end
    for (int s = 0; s < 2; s++) begin
      set_cpu(1'b0, 2'b00, s[0], 32'h5, 32'h0, 32'h104);
      exp = ref_load(32'h5, 2'b00, s[0]);
      step();
      checks++;
      if (cpu_rvalid !== 1'b1 || cpu_rdata !== exp) begin
        errors++; $display("FAIL lb_sext%0d: got v=%b %h required v=1 %h", s, cpu_rvalid, cpu_rdata, exp);
      end
    end
    idle_inputs();
    step();
    checks++;
    if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_pulse: got %b required 0", cpu_rvalid); end
  endtask

  task automatic test_half();
    logic [31:0] exp;
    set_cpu(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_8001, 32'h200);
    #1;
    checks++;
    if (dm_be !== 4'b1100 || dm_wdata !== 32'h8001_8001 || dm_we !== 1'b1) begin
      errors++; $display("FAIL sh: got be=%b wd=%h we=%b required 1100 80018001 1", dm_be, dm_wdata, dm_we);
    end
    ref_store(32'h12, 2'b01, 32'h8001);
    step();
    for (int s = 1; s >= 0; s--) begin
      set_cpu(1'b0, 2'b01, s[0], 32'h12, 32'h0, 32'h204);
      exp = ref_load(32'h12, 2'b01, s[0]);
      step();
      checks++;
      if (cpu_rvalid !== 1'b1 || cpu_rdata !== exp) begin
        errors++; $display("FAIL lh_sext%0d: got v=%b %h required v=1 %h", s, cpu_rvalid, cpu_rdata, exp);
      end
    end
    idle_inputs();
  endtask

  task automatic test_starve(input string tag);
    logic exp_dma;
    set_cpu(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h300);
    set_dma(1'b0, 32'h200, 32'h0);
    for (int i = 0; i < 10; i++) begin
      #1;
      exp_dma = ((i % 5) == 4);
      checks++;
      if (dma_gnt !== exp_dma || cpu_gnt !== !exp_dma) begin
        errors++; $display("FAIL %s_cyc%0d: got cpu=%b dma=%b required dma=%b", tag, i, cpu_gnt, dma_gnt, exp_dma);
      end
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_misaligned();
    logic [31:0] exp;
    set_cpu(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h400);
    #1;
    checks++;
    if ({cpu_gnt, dm_we, dm_be} !== 6'b10_0000) begin
      errors++; $display("FAIL mis_lw_drive: got %b required 100000", {cpu_gnt, dm_we, dm_be});
    end
    step();
    checks++;
    if ({cpu_err, cpu_rvalid} !== 2'b11 || cpu_rdata !== 32'h0) begin
      errors++; $display("FAIL mis_lw_ret: got err=%b v=%b %h required 1 1 0", cpu_err, cpu_rvalid, cpu_rdata);
    end
    set_cpu(1'b1, 2'b01, 1'b0, 32'h11, 32'h0000_FFFF, 32'h404);
    #1;
    checks++;
    if ({cpu_gnt, dm_we, dm_be} !== 6'b10_0000) begin
      errors++; $display("FAIL mis_sh_drive: got %b required 100000", {cpu_gnt, dm_we, dm_be});
    end
    step();
    checks++;
    if ({cpu_err, cpu_rvalid} !== 2'b10) begin
      errors++; $display("FAIL mis_sh_ret: got err=%b v=%b required 1 0", cpu_err, cpu_rvalid);
    end
    set_cpu(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'h408);
    exp = ref_load(32'h10, 2'b01, 1'b0);
    step();
    checks++;
    if (cpu_err !== 1'b0 || cpu_rdata !== exp) begin
      errors++; $display("FAIL mis_unchanged: got err=%b %h required 0 %h", cpu_err, cpu_rdata, exp);
    end
    idle_inputs();
  endtask

  task automatic test_range();
    logic [31:0] exp;
    set_cpu(1'b1, 2'b10, 1'b0, 32'h2FFC, 32'hCAFE_F00D, 32'h500);
    ref_store(32'h2FFC, 2'b10, 32'hCAFE_F00D);
    step();
    set_cpu(1'b1, 2'b10, 1'b0, 32'h3000, 32'h1234_5678, 32'h504);
    #1;
    checks++;
    if (cpu_gnt !== 1'b1 || dm_we !== 1'b0) begin
      errors++; $display("FAIL oor_sw: got gnt=%b we=%b required 1 0", cpu_gnt, dm_we);
    end
    step();
    checks++;
    if (mem[12'hC00] !== 32'h0) begin errors++; $display("FAIL oor_mem: got %h required 0", mem[12'hC00]); end
    set_cpu(1'b0, 2'b10, 1'b0, 32'h3000, 32'h0, 32'h508);
    step();
    checks++;
    if ({cpu_rvalid, cpu_err} !== 2'b10 || cpu_rdata !== 32'h0) begin
      errors++; $display("FAIL oor_lw: got v=%b err=%b %h required 1 0 0", cpu_rvalid, cpu_err, cpu_rdata);
    end
    set_cpu(1'b0, 2'b10, 1'b0, 32'h2FFC, 32'h0, 32'h50C);
    exp = ref_load(32'h2FFC, 2'b10, 1'b0);
    step();
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== exp) begin
      errors++; $display("FAIL last_word: got v=%b %h required 1 %h", cpu_rvalid, cpu_rdata, exp);
    end
    idle_inputs();
  endtask

  task automatic test_dma();
    logic [31:0] exp;
    cpu_pc = 32'h1234;
    set_dma(1'b1, 32'h43, 32'hDEAD_BEEF);
    #1;
    checks++;
    if ({dma_gnt, cpu_gnt, dm_we, dm_be} !== 7'b101_1111 || dm_addr !== 32'h40 || dm_pc !== 32'h0) begin
      errors++; $display("FAIL dma_sw: got %b a=%h pc=%h required 1011111 40 0", {dma_gnt, cpu_gnt, dm_we, dm_be}, dm_addr, dm_pc);
    end
    ref_store(32'h40, 2'b10, 32'hDEAD_BEEF);
    step();
    set_dma(1'b0, 32'h41, 32'h0);
    exp = ref_load(32'h40, 2'b10, 1'b0);
    step();
    checks++;
    if (dma_rvalid !== 1'b1 || dma_rdata !== exp) begin
      errors++; $display("FAIL dma_lw: got v=%b %h required 1 %h", dma_rvalid, dma_rdata, exp);
    end
    idle_inputs();
    set_cpu(1'b0, 2'b00, 1'b1, 32'h42, 32'h0, 32'h600);
    exp = ref_load(32'h42, 2'b00, 1'b1);
    step();
    checks++;
    if (cpu_rdata !== exp || dma_rvalid !== 1'b0) begin
      errors++; $display("FAIL dma_then_cpu: got %h dv=%b required %h 0", cpu_rdata, dma_rvalid, exp);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    logic [31:0] a, wd, exp;
    logic [1:0]  sz;
    logic        we, sx;
    for (int n = 0; n < 200; n++) begin
      idle_inputs();
      a  = 32'($urandom_range(0, 1023));
      wd = $urandom;
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) != 0) begin
        sz = 2'($urandom_range(0, 3));
        sx = 1'($urandom_range(0, 1));
        a  = a & ~(32'(nbytes(sz)) - 32'd1);
        set_cpu(we, sz, sx, a, wd, $urandom);
        exp = ref_load(a, sz, sx);
        if (we) ref_store(a, sz, wd);
        #1;
        checks++;
        if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL rnd_cpu_gnt%0d: got %b required 1", n, cpu_gnt); end
        step();
        checks++;
        if (cpu_rvalid !== !we || (!we && cpu_rdata !== exp)) begin
          errors++; $display("FAIL rnd_cpu%0d: a=%h sz=%0d got v=%b %h required v=%b %h", n, a, sz, cpu_rvalid, cpu_rdata, !we, exp);
        end
      end else begin
        set_dma(we, a, wd);
        exp = ref_load(a & ~32'd3, 2'b10, 1'b0);
        if (we) ref_store(a & ~32'd3, 2'b10, wd);
        step();
        checks++;
        if (dma_rvalid !== !we || (!we && dma_rdata !== exp)) begin
          errors++; $display("FAIL rnd_dma%0d: a=%h got v=%b %h required v=%b %h", n, a, dma_rvalid, dma_rdata, !we, exp);
        end
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid();
    set_dma(1'b0, 32'h40, 32'h0);
    #1;
    checks++;
    if (dma_gnt !== 1'b1) begin errors++; $display("FAIL rmid_gnt: got %b required 1", dma_gnt); end
    step();
    reset = 1'b1;
    idle_inputs();
    cpu_req = 1'b1;
    step();
    checks++;
    if ({cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, cpu_err, dm_we, dm_be} !== 10'b0 || dma_rdata !== 32'h0) begin
      errors++; $display("FAIL rmid_outs: got %b %h required 0", {cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, cpu_err, dm_we, dm_be}, dma_rdata);
    end
    reset = 1'b0;
    idle_inputs();
    test_starve("rmid_starve");
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) ref_b[i] = 8'h00;
    test_reset();
    test_byte();
    test_half();
    test_starve("starve");
    test_misaligned();
    test_range();
    test_dma();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-requester access controller for the single-port data memory. It shares the memory between the CPU M-stage load/store port and a word-only DMA port. It also generates byte enables and write-lane replication for sb/sh/sw, and extracts lb/lbu/lh/lhu/lw load data. It sits between the M-stage and the DM, registering read data so that load results return with fixed one-cycle latency.

## Interface
- DM_LIMIT, 32'h0000_3000, first address outside DM; accesses at or above it are suppressed
- STARVE_MAX, 4, consecutive denied DMA cycles before DMA is forced a grant (range 1..15)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cpu_req  in  1  CPU access request, held until cpu_gnt
- cpu_we  in  1  1 = store, 0 = load
- cpu_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word
- cpu_sext  in  1  loads only: sign-extend byte/half
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  store data, right-aligned
- cpu_pc  in  32  PC of the access, forwarded for the write log
- cpu_gnt  out  1  access accepted this cycle
- cpu_rvalid  out  1  load data valid, one cycle after grant
- cpu_rdata  out  32  extended load data
- cpu_err  out  1  one-cycle pulse aligned with rvalid slot: misaligned access
- dma_req, dma_we  in  1 each  DMA request / store
- dma_addr, dma_wdata  in  32 each  word address (bits[1:0] ignored), data
- dma_gnt, dma_rvalid  out  1 each
- dma_rdata  out  32
- dm_we  out  1  memory write strobe
- dm_addr, dm_wdata, dm_pc  out  32 each  to memory
- dm_be  out  4  byte enables
- dm_rdata  in  32  combinational memory read word at dm_addr[13:2]

## Operation
- One grant per cycle. The grant and the memory drive are combinational in the same cycle; at most one of cpu_gnt/dma_gnt is high.
- Priority: CPU wins by default. starve_cnt (4 b) increments each cycle dma_req is high and dma_gnt is low, and clears on dma_gnt or when dma_req is low.
- When starve_cnt == STARVE_MAX, DMA is granted regardless of cpu_req, and cpu_gnt is 0 that cycle (the CPU stalls).
- With no grant: dm_we=0, dm_be=0, dm_addr=0.
- CPU byte enables by size and addr[1:0]:
  - byte: 0001/0010/0100/1000 for offset 0/1/2/3.
  - half: 0011 at offset 0, 1100 at offset 2.
  - word: 1111.
- Write lane replication: byte → {4{wdata[7:0]}}; half → {2{wdata[15:0]}}; word unchanged.
- DMA always uses be=1111 and addr={dma_addr[31:2],2'b00}.
- Misaligned (half with addr[0]=1, word with addr[1:0]≠0):
  - The access is granted, but dm_we=0 and dm_be=0.
  - Next cycle: cpu_err=1; cpu_rvalid=1 for loads with rdata=0.
- Out of range ({addr[31:2],00} ≥ DM_LIMIT): dm_we=0. A load returns 0 with rvalid; no error is flagged.
- Load extraction uses registered offset, size and sext:
  - byte: select lane, then zero- or sign-extend.
  - half: select [15:0] or [31:16], then extend.
  - word: passthrough.
- dm_pc = cpu_pc on CPU grants, 0 on DMA grants.

## Timing
- Reset values: every output 0, starve_cnt 0, all read-return registers 0.
- Load latency is 1 cycle: the cycle after the grant, rvalid=1 and rdata holds the registered, extracted word. rvalid is a one-cycle pulse.
- Stores take effect at the memory's clock edge ending the grant cycle. No rvalid is produced for stores.
- Back-to-back grants every cycle are legal. A CPU load immediately following a CPU store to the same word returns the new value, because the memory updated at the prior edge.
- Simultaneous cpu_req and dma_req with starve_cnt < STARVE_MAX: CPU granted, counter increments.
- Reset asserted mid-operation: a pending rvalid/err is dropped the next cycle and starve_cnt clears. A grant in the reset cycle is 0.

## Structure
- Shared package holds:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD encodings
  - DM_LIMIT default
  - function be_gen(size, off)
  - function load_ext(word, size, off, sext)
- One sub-module is natural: dm_lane_unit, the combinational BE generation, write replication and load extraction, instantiated once. The arbiter holds the counter, grant logic and return registers.

## Test plan
- CPU sb, addr 0x0000_0005, wdata 0x0000_00AB → dm_be=0010, dm_wdata=0xABABABAB, dm_we=1. Then lbu at the same address → next-cycle rdata=0x0000_00AB. Then lb → 0xFFFF_FFAB.
- CPU sh, addr 0x12, wdata 0x8001 → be=1100. Then lh → 0xFFFF_8001; lhu → 0x0000_8001.
- cpu_req and dma_req held high continuously, STARVE_MAX=4 → CPU granted 4 cycles, DMA on the 5th, counter cleared, pattern repeats.
- Misaligned lw at 0x0000_0102 → gnt=1, dm_we=0, be=0. Next cycle cpu_err=1, rvalid=1, rdata=0.
- sw at 0x0000_3000 → dm_we=0, memory unchanged. lw at 0x0000_2FFC → valid data.
- DMA load issued, reset asserted the following cycle → dma_rvalid=0, all outputs 0. After reset releases, starve_cnt starts from 0.
